// File: rtl/pixel_shadow_buffer_pkg.sv
// pixel_shadow_buffer_pkg: shared constants, state encoding and address helper for the shadow framebuffer.
package pixel_shadow_buffer_pkg;
  localparam int DEF_X_MAX = 160;
  localparam int DEF_Y_MAX = 120;
  localparam int WORDS = DEF_X_MAX * DEF_Y_MAX;
  localparam int ADDR_W = 15;
  typedef enum logic [1:0] {CLEAR, IDLE, RD1, RD2} state_t;
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] px, input logic [6:0] py);
    return ADDR_W'({py, 7'b0}) + ADDR_W'({py, 5'b0}) + ADDR_W'(px);
  endfunction
endpackage

// File: rtl/pixel_shadow_buffer_ram.sv
// pixel_ram: single-port synchronous-read memory, read-before-write, inferable as block RAM.
module pixel_ram #(
  parameter int DEPTH = 19200,
  parameter int AW = 15,
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/pixel_shadow_buffer.sv
// pixel_shadow_buffer: taps the plot stream into a 160x120 shadow framebuffer and serves req/ack pixel read-back.
module pixel_shadow_buffer
  import pixel_shadow_buffer_pkg::*;
#(
  parameter int X_MAX = DEF_X_MAX,
  parameter int Y_MAX = DEF_Y_MAX,
  parameter int COLOUR_W = 3,
  parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = '0,
  parameter logic [COLOUR_W-1:0] OOR_COLOUR = '1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                plot,
  input  logic [7:0]          x,
  input  logic [6:0]          y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                rd_req,
  input  logic [7:0]          rd_x,
  input  logic [6:0]          rd_y,
  output logic                rd_ack,
  output logic [COLOUR_W-1:0] rd_colour,
  input  logic                clear_req,
  output logic                busy,
  output logic [7:0]          drop_count
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] clear_addr, ram_addr;
  logic [COLOUR_W-1:0] ram_din, ram_dout;
  logic ram_we, plot_ok, rd_oor, rd_oor_q, accept, drop, last;
  assign plot_ok = plot && x < 8'(X_MAX) && y < 7'(Y_MAX);
  assign rd_oor = !(rd_x < 8'(X_MAX) && rd_y < 7'(Y_MAX));
  assign busy = state == CLEAR;
  assign last = clear_addr == ADDR_W'(WORDS - 1);
  assign drop = plot && (busy || (state == IDLE && clear_req));
  // The read address is presented in the acceptance cycle, which never carries a write,
  // so the port is free for a plot in RD1 and the data captured is the pre-write value.
  always_comb begin
    state_nx = state == RD1 ? RD2 : state == RD2 ? IDLE : state;
    ram_we = 1'b0;
    ram_addr = pix_addr(rd_x, rd_y);
    ram_din = colour;
    accept = 1'b0;
    if (busy) begin
      ram_we = 1'b1;
      ram_addr = clear_addr;
      ram_din = CLEAR_COLOUR;
      state_nx = last ? IDLE : CLEAR;
    end else if (state == IDLE && clear_req) begin
      state_nx = CLEAR;
    end else if (plot) begin
      ram_we = plot_ok;
      ram_addr = pix_addr(x, y);
    end else if (state == IDLE && rd_req) begin
      accept = 1'b1;
      state_nx = RD1;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= CLEAR;
      clear_addr <= '0;
      rd_oor_q <= 1'b0;
      rd_ack <= 1'b0;
      rd_colour <= '0;
      drop_count <= '0;
    end else begin
      state <= state_nx;
      clear_addr <= (busy && !last) ? clear_addr + 1'b1 : '0;
      rd_ack <= state == RD1;
      if (accept) rd_oor_q <= rd_oor;
      if (state == RD1) rd_colour <= rd_oor_q ? OOR_COLOUR : ram_dout;
      if (drop) drop_count <= drop_count + 8'(~&drop_count);
    end
  end
  pixel_ram #(.DEPTH(WORDS), .AW(ADDR_W), .DW(COLOUR_W)) u_ram (
    .clk (clk),
    .we  (ram_we),
    .addr(ram_addr),
    .din (ram_din),
    .dout(ram_dout)
  );
endmodule

// File: tb/tb_pixel_shadow_buffer.sv
// tb_pixel_shadow_buffer: directed self-checking bench for pixel_shadow_buffer.
module tb_pixel_shadow_buffer;
  logic clk = 0, resetn = 0, plot = 0, rd_req = 0, clear_req = 0;
  logic [7:0] x = 0, rd_x = 0;
  logic [6:0] y = 0, rd_y = 0;
  logic [2:0] colour = 0;
  logic rd_ack, busy;
  logic [2:0] rd_colour;
  logic [7:0] drop_count;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  pixel_shadow_buffer dut (
    .clk(clk), .resetn(resetn), .plot(plot), .x(x), .y(y), .colour(colour),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_ack(rd_ack), .rd_colour(rd_colour),
    .clear_req(clear_req), .busy(busy), .drop_count(drop_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_plot(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
    plot = 1; x = px; y = py; colour = pc;
    step();
    plot = 0;
  endtask
  task automatic rd_finish(input string tag, input int lat0, input int exp_lat, input logic [2:0] exp_c);
    int n = lat0;
    while (!rd_ack && n < 50) begin step(); n++; end
    rd_req = 0;
    check({tag, " latency"}, n, exp_lat);
    check({tag, " colour"}, rd_colour, exp_c);
    step();
    check({tag, " ack pulse"}, rd_ack, 0);
  endtask
  task automatic rd(input string tag, input logic [7:0] px, input logic [6:0] py, input logic [2:0] exp_c);
    rd_x = px; rd_y = py; rd_req = 1;
    rd_finish(tag, 0, 2, exp_c);
  endtask
  task automatic sweep(input string tag, input int exp_len);
    int n = 0;
    int acks = 0;
    while (busy && n < 20000) begin step(); n++; if (rd_ack) acks++; end
    if (exp_len > 0) check({tag, " sweep cycles"}, n, exp_len);
    check({tag, " busy low"}, busy, 0);
    check({tag, " no ack in sweep"}, acks, 0);
  endtask
  initial begin
    step(); step();
    check("reset busy", busy, 1);
    check("reset ack", rd_ack, 0);
    check("reset colour", rd_colour, 0);
    check("reset drops", drop_count, 0);
    resetn = 1;
    sweep("init", 19200);
    rd("rd00", 0, 0, 3'b000);
    do_plot(10, 60, 3'b111);
    rd("rd10_60", 10, 60, 3'b111);
    rd("rd11_60", 11, 60, 3'b000);
    check("idle plots not dropped", drop_count, 0);
    rd("oor x", 200, 5, 3'b111);
    rd("oor y", 5, 125, 3'b111);
    do_plot(170, 10, 3'b101);
    rd("alias 10_11", 10, 11, 3'b000);
    check("oor plot not counted", drop_count, 0);
    plot = 1; x = 20; y = 20; colour = 3'b010;
    rd_x = 20; rd_y = 20; rd_req = 1;
    step();
    plot = 0;
    rd_finish("plot wins", 1, 3, 3'b010);
    rd_x = 30; rd_y = 30; rd_req = 1;
    step();
    plot = 1; x = 30; y = 30; colour = 3'b110;
    step();
    plot = 0; rd_req = 0;
    check("rbw ack", rd_ack, 1);
    check("rbw old data", rd_colour, 3'b000);
    step();
    rd("rbw new data", 30, 30, 3'b110);
    clear_req = 1;
    step();
    clear_req = 0;
    check("clear busy", busy, 1);
    for (int i = 0; i < 300; i++) begin
      plot = 1; x = 8'(i % 160); y = 7'(i / 160); colour = 3'b101;
      step();
    end
    plot = 0;
    check("drops saturate", drop_count, 255);
    sweep("clear", 0);
    rd("cleared 10_60", 10, 60, 3'b000);
    rd("cleared 20_20", 20, 20, 3'b000);
    rd("dropped 5_0", 5, 0, 3'b000);
    rd("dropped 100_1", 100, 1, 3'b000);
    do_plot(1, 1, 3'b011);
    rd_x = 1; rd_y = 1; rd_req = 1;
    step();
    resetn = 0; rd_req = 0;
    #1;
    check("abort busy", busy, 1);
    check("abort drops", drop_count, 0);
    step();
    check("abort no ack", rd_ack, 0);
    check("abort busy next", busy, 1);
    step();
    resetn = 1;
    sweep("rerun", 19200);
    check("rerun drops", drop_count, 0);
    rd("rerun 1_1", 1, 1, 3'b000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pixel_shadow_buffer.md
Name: pixel_shadow_buffer

Overview:
Receiving end of the plot interface (x, y, colour, plot) that drives the VGA adapter. Taps the same plot stream into a 160x120 shadow copy of the framebuffer. Serves pixel read-back over a req/ack handshake, so game logic (ball/paddle collision) can query what is on screen. Sits beside vga_adapter; the drawing FSMs are unchanged.

Parameters:
X_MAX, 160, horizontal resolution; valid x is 0..X_MAX-1
Y_MAX, 120, vertical resolution; valid y is 0..Y_MAX-1
COLOUR_W, 3, bits per pixel
CLEAR_COLOUR, 3'b000, value written by the clear sweep
OOR_COLOUR, 3'b111, value returned for out-of-range reads (acts as a wall)

Ports:
clk  in  1  system clock (CLOCK_50 at top level)
resetn  in  1  asynchronous active-low reset
plot  in  1  write strobe, same as the vga_adapter plot input
x  in  8  write column
y  in  7  write row
colour  in  COLOUR_W  write data
rd_req  in  1  read request; held high until rd_ack
rd_x  in  8  read column; stable while rd_req is high
rd_y  in  7  read row; stable while rd_req is high
rd_ack  out  1  one-cycle pulse; rd_colour is valid from this cycle
rd_colour  out  COLOUR_W  read result; held until the next ack
clear_req  in  1  pulse starts a full clear sweep
busy  out  1  high while clearing
drop_count  out  8  number of plots dropped while busy; saturates at 255

Behaviour:
- Storage: X_MAX*Y_MAX words of COLOUR_W bits, single port, synchronous read (1-cycle latency).
- Address = y*160 + x, computed as (y<<7)+(y<<5)+x, 15 bits wide.
- Reset (async): state=CLEAR, clear_addr=0, rd_ack=0, rd_colour=0, drop_count=0, busy=1.
- Memory contents are not reset directly; the clear sweep initialises them.
- CLEAR state:
  - One word per cycle: writes CLEAR_COLOUR at clear_addr, then clear_addr++.
  - After address 19199 the next state is IDLE. A sweep is exactly 19200 cycles.
  - busy=1 for the whole sweep.
  - Every plot=1 cycle is dropped and increments drop_count (saturating).
  - rd_req is not accepted; it stays pending. clear_req is ignored.
- IDLE state, priority order per cycle:
  - clear_req: enter CLEAR at address 0; busy rises the next cycle. Any plot in the same cycle is dropped and counted.
  - plot: if x<X_MAX and y<Y_MAX, write colour in this cycle. Out-of-range plots are silently ignored and not counted.
  - rd_req (only with no plot and no clear_req in this cycle): latch the address and range flag, go to RD1.
- RD1: RAM read issued; go to RD2. A plot in RD1 is performed, because the write has priority and the read has already been addressed.
- RD2 (read accepted at cycle N, RD2 at N+2):
  - rd_ack=1.
  - rd_colour = RAM data, or OOR_COLOUR if the latched address was out of range.
  - Return to IDLE. The requester drops rd_req after sampling ack.
  - If rd_req is still high in IDLE, it is treated as a new request.
- Read latency: acceptance to ack is 2 cycles. A plot in the acceptance cycle delays acceptance, so the stall is unbounded under a continuous plot stream.
- A write to the same address in RD1 returns the old data (read-before-write).
- Reset mid-read or mid-clear: immediate abort, restart CLEAR from address 0; no ack is issued.

Decomposition:
- Shared package holds: X_MAX/Y_MAX defaults, the 19200 word count, the address-width constant, and the state encoding {CLEAR, IDLE, RD1, RD2}.
- One sub-module: pixel_ram, a single-port synchronous-read memory (we, addr, din, dout). It is inferable as block RAM.

Test Plan:
- Release reset, no stimulus -> busy=1 for 19200 cycles then 0; a read of (0,0) then returns 3'b000.
- After clear, plot (10,60,3'b111), then rd_req (10,60) -> rd_ack 2 cycles after acceptance, rd_colour=3'b111; a read of (11,60) returns 3'b000.
- rd_req (200,5) or (5,125) -> rd_ack after 2 cycles, rd_colour=3'b111 (OOR); plot (170,10) leaves memory unchanged.
- Plot (20,20,3'b010) in the same cycle as rd_req (20,20) -> plot wins, read accepted next cycle, returns 3'b010.
- Issue clear_req, then 300 plots during the sweep -> drop_count=255 (saturated); none of the plots persist after busy falls.
- Assert resetn low during RD1 -> no rd_ack, busy=1 next cycle, a full 19200-cycle sweep repeats, drop_count=0.
